// File: rtl/wb_pkg.sv
// Write-back stage shared definitions: default widths and FSM state encoding.
package wb_pkg;

    localparam int XLEN_D   = 64;
    localparam int RIDX_W_D = 5;
    localparam int NCH_D    = 2;
    localparam int CNT_W_D  = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_SCAN = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } wb_state_t;

endpackage

// File: rtl/wb_pick.sv
// Lowest-set-bit priority encoder: selects the lowest pending channel.
module wb_pick #(
    parameter int N     = 2,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_any
);

    // Scan upward; the first set bit found wins.
    always_comb begin
        o_sel = '0;
        o_any = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (i_req[i] && !o_any) begin
                o_sel = SEL_W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: pulls one entry from the result buffer, retires each
// pending channel to the register file in channel order, then toggles sig_e.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN   = XLEN_D,
    parameter int RIDX_W = RIDX_W_D,
    parameter int NCH    = NCH_D,
    parameter int CNT_W  = CNT_W_D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  buf_avail,
    output logic                  buf_re,
    input  logic                  buf_rack,
    input  logic [NCH-1:0]        wb_e,
    input  logic [NCH*RIDX_W-1:0] idx_in,
    input  logic [NCH*XLEN-1:0]   din,
    output logic                  reg_we,
    output logic [RIDX_W-1:0]     reg_idx,
    output logic [XLEN-1:0]       reg_dout,
    input  logic                  reg_wack,
    output logic                  sig_e,
    output logic                  fwd_valid,
    output logic [RIDX_W-1:0]     fwd_idx,
    output logic [XLEN-1:0]       fwd_data,
    output logic                  busy,
    output logic [CNT_W-1:0]      wb_count
);

    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

    wb_state_t                    r_state;
    logic                         r_buf_re;
    logic                         r_reg_we;
    logic [RIDX_W-1:0]            r_reg_idx;
    logic [XLEN-1:0]              r_reg_dout;
    logic                         r_sig_e;
    logic [CNT_W-1:0]             r_count;
    logic [NCH-1:0]               r_pend;
    logic [NCH-1:0][RIDX_W-1:0]   r_idx;
    logic [NCH-1:0][XLEN-1:0]     r_data;
    logic [SEL_W-1:0]             r_cur;

    logic [NCH-1:0][RIDX_W-1:0]   w_idx;
    logic [NCH-1:0]               w_pend_new;
    logic [SEL_W-1:0]             w_sel;
    logic                         w_any;

    assign w_idx = idx_in;

    // Pending mask at latch: drop index-0 writes and any channel overwritten by a higher one.
    always_comb begin
        w_pend_new = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            w_pend_new[i] = wb_e[i] && (w_idx[i] != '0);
        end
        for (int unsigned i = 0; i < NCH; i++) begin
            for (int unsigned j = i + 1; j < NCH; j++) begin
                if (wb_e[j] && (w_idx[j] != '0) && (w_idx[j] == w_idx[i])) begin
                    w_pend_new[i] = 1'b0;
                end
            end
        end
    end

    wb_pick #(.N(NCH), .SEL_W(SEL_W)) u_pick (
        .i_req (r_pend),
        .o_sel (w_sel),
        .o_any (w_any)
    );

    // Control FSM with registered handshake and write outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_buf_re   <= 1'b0;
            r_reg_we   <= 1'b0;
            r_reg_idx  <= '0;
            r_reg_dout <= '0;
            r_sig_e    <= 1'b1;
            r_count    <= '0;
            r_pend     <= '0;
            r_idx      <= '0;
            r_data     <= '0;
            r_cur      <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (buf_avail) begin
                        r_buf_re <= 1'b1;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (buf_rack) begin
                        r_idx    <= idx_in;
                        r_data   <= din;
                        r_pend   <= w_pend_new;
                        r_buf_re <= 1'b0;
                        r_state  <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!w_any) begin
                        r_state <= S_DONE;
                    end else begin
                        r_reg_idx  <= r_idx[w_sel];
                        r_reg_dout <= r_data[w_sel];
                        r_reg_we   <= 1'b1;
                        r_cur      <= w_sel;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (reg_wack) begin
                        r_reg_we      <= 1'b0;
                        r_pend[r_cur] <= 1'b0;
                        r_count       <= r_count + CNT_W'(1);
                        r_state       <= S_SCAN;
                    end
                end
                S_DONE: begin
                    r_sig_e <= ~r_sig_e;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign buf_re    = r_buf_re;
    assign reg_we    = r_reg_we;
    assign reg_idx   = r_reg_idx;
    assign reg_dout  = r_reg_dout;
    assign sig_e     = r_sig_e;
    assign wb_count  = r_count;
    assign fwd_valid = (r_state == S_WAIT);
    assign fwd_idx   = r_reg_idx;
    assign fwd_data  = r_reg_dout;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: stimulus pushes expected writes, a monitor
// checks each presented register write, a responder acknowledges writes.
module tb_wb_stage;

    localparam int XLEN   = 64;
    localparam int RIDX_W = 5;
    localparam int NCH    = 2;
    localparam int CNT_W  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  buf_avail;
    logic                  buf_re;
    logic                  buf_rack;
    logic [NCH-1:0]        wb_e;
    logic [NCH*RIDX_W-1:0] idx_in;
    logic [NCH*XLEN-1:0]   din;
    logic                  reg_we;
    logic [RIDX_W-1:0]     reg_idx;
    logic [XLEN-1:0]       reg_dout;
    logic                  reg_wack;
    logic                  sig_e;
    logic                  fwd_valid;
    logic [RIDX_W-1:0]     fwd_idx;
    logic [XLEN-1:0]       fwd_data;
    logic                  busy;
    logic [CNT_W-1:0]      wb_count;

    wb_stage #(.XLEN(XLEN), .RIDX_W(RIDX_W), .NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .buf_avail (buf_avail),
        .buf_re    (buf_re),
        .buf_rack  (buf_rack),
        .wb_e      (wb_e),
        .idx_in    (idx_in),
        .din       (din),
        .reg_we    (reg_we),
        .reg_idx   (reg_idx),
        .reg_dout  (reg_dout),
        .reg_wack  (reg_wack),
        .sig_e     (sig_e),
        .fwd_valid (fwd_valid),
        .fwd_idx   (fwd_idx),
        .fwd_data  (fwd_data),
        .busy      (busy),
        .wb_count  (wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RIDX_W-1:0] idx;
        logic [XLEN-1:0]   data;
    } wr_t;

    wr_t              exp_q[$];
    int               checks    = 0;
    int               failures  = 0;
    logic [CNT_W-1:0] exp_count = '0;
    logic             exp_sig   = 1'b1;
    int               wack_dly  = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [RIDX_W-1:0] idx, input logic [XLEN-1:0] data);
        wr_t w;
        w.idx  = idx;
        w.data = data;
        exp_q.push_back(w);
        exp_count = exp_count + CNT_W'(1);
    endtask

    // Write acknowledge responder: wack pulses wack_dly cycles after reg_we is seen.
    initial begin
        int wcnt;
        wcnt     = 0;
        reg_wack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                reg_wack = 1'b0;
                wcnt     = 0;
            end else if (reg_wack) begin
                reg_wack = 1'b0;
            end else if (reg_we) begin
                if (wcnt >= wack_dly) begin
                    reg_wack = 1'b1;
                    wcnt     = 0;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    // Monitor: every cycle a write is presented it must match the queue head; pop on ack.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!rst && reg_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got idx=%0d data=0x%0h expected no write", reg_idx, reg_dout);
                end else begin
                    chk("mon.reg_idx",   reg_idx,   exp_q[0].idx);
                    chk("mon.reg_dout",  reg_dout,  exp_q[0].data);
                    chk("mon.fwd_valid", fwd_valid, 1'b1);
                    chk("mon.fwd_idx",   fwd_idx,   exp_q[0].idx);
                    chk("mon.fwd_data",  fwd_data,  exp_q[0].data);
                    if (reg_wack) void'(exp_q.pop_front());
                end
            end
        end
    end

    // Drive one buffer entry through the stage and check the completion.
    task automatic run_entry(input logic [1:0] we, input logic [4:0] i0, input logic [4:0] i1,
                             input logic [63:0] d0, input logic [63:0] d1,
                             input int rack_dly, input bit drop_avail, input int nwr,
                             input string tag);
        int n;
        int hi;
        @(negedge clk);
        buf_avail = 1'b1;
        wb_e      = 2'b11;
        idx_in    = {5'd1, 5'd1};
        din       = {64'hBAD1, 64'hBAD0};
        n = 0;
        while (!buf_re && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".re_latency"}, n, 1);
        if (drop_avail) buf_avail = 1'b0;
        hi = 0;
        for (int k = 0; k < rack_dly; k++) begin
            if (buf_re) hi++;
            @(negedge clk);
        end
        buf_rack = 1'b1;
        wb_e     = we;
        idx_in   = {i1, i0};
        din      = {d1, d0};
        if (buf_re) hi++;
        @(negedge clk);
        buf_rack  = 1'b0;
        buf_avail = 1'b0;
        wb_e      = 2'b11;
        idx_in    = {5'd2, 5'd2};
        din       = {64'hBAD3, 64'hBAD2};
        chk({tag, ".re_high_cycles"}, hi, rack_dly + 1);
        chk({tag, ".re_dropped"}, buf_re, 1'b0);
        chk({tag, ".we_scan"}, reg_we, 1'b0);
        @(negedge clk);
        chk({tag, ".we_first"}, reg_we, (nwr > 0) ? 1'b1 : 1'b0);
        n = 0;
        while (sig_e === exp_sig && n < 100) begin
            @(negedge clk);
            n++;
        end
        exp_sig = ~exp_sig;
        chk({tag, ".sig_e"}, sig_e, exp_sig);
        chk({tag, ".wb_count"}, wb_count, exp_count);
        chk({tag, ".busy_idle"}, busy, 1'b0);
        chk({tag, ".writes_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        buf_avail = 1'b0;
        buf_rack  = 1'b0;
        wb_e      = '0;
        idx_in    = '0;
        din       = '0;
        repeat (3) @(negedge clk);
        chk("rst.buf_re",    buf_re,    1'b0);
        chk("rst.reg_we",    reg_we,    1'b0);
        chk("rst.reg_idx",   reg_idx,   5'd0);
        chk("rst.reg_dout",  reg_dout,  64'd0);
        chk("rst.sig_e",     sig_e,     1'b1);
        chk("rst.wb_count",  wb_count,  4'd0);
        chk("rst.busy",      busy,      1'b0);
        chk("rst.fwd_valid", fwd_valid, 1'b0);
        rst = 1'b0;

        // Single write on channel 0.
        push_wr(5'd3, 64'h55);
        run_entry(2'b01, 5'd3, 5'd0, 64'h55, 64'h0, 0, 1'b0, 1, "single");
        // Both channels to the same index: channel 1 wins.
        push_wr(5'd4, 64'hAA);
        run_entry(2'b11, 5'd4, 5'd4, 64'h11, 64'hAA, 0, 1'b0, 1, "dup_idx");
        // Index 0 suppressed.
        push_wr(5'd7, 64'hC3);
        run_entry(2'b11, 5'd0, 5'd7, 64'h99, 64'hC3, 0, 1'b0, 1, "idx_zero");
        // Empty entry still toggles sig_e.
        run_entry(2'b00, 5'd6, 5'd6, 64'h1, 64'h2, 0, 1'b0, 0, "empty");
        // Two writes, channel order, slower acknowledge.
        wack_dly = 3;
        push_wr(5'd2, 64'h1234);
        push_wr(5'd9, 64'hDEAD_BEEF_0000_0001);
        run_entry(2'b11, 5'd2, 5'd9, 64'h1234, 64'hDEAD_BEEF_0000_0001, 0, 1'b0, 2, "two_wr");
        wack_dly = 1;

        // Acknowledges while idle must be ignored.
        @(negedge clk);
        buf_rack = 1'b1;
        reg_wack = 1'b0;
        repeat (3) @(negedge clk);
        buf_rack = 1'b0;
        chk("stray_rack.busy",   busy,     1'b0);
        chk("stray_rack.buf_re", buf_re,   1'b0);
        chk("stray_rack.count",  wb_count, exp_count);

        // Late acknowledge with buf_avail dropped while waiting.
        push_wr(5'd12, 64'hF00D);
        run_entry(2'b01, 5'd12, 5'd0, 64'hF00D, 64'h0, 5, 1'b1, 1, "late_rack");

        // Reset while a write is waiting for acknowledge.
        push_wr(5'd5, 64'h77);
        @(negedge clk);
        buf_avail = 1'b1;
        n = 0;
        while (!buf_re && n < 20) begin
            @(negedge clk);
            n++;
        end
        buf_rack = 1'b1;
        wb_e     = 2'b01;
        idx_in   = {5'd0, 5'd5};
        din      = {64'h0, 64'h77};
        @(negedge clk);
        buf_rack  = 1'b0;
        buf_avail = 1'b0;
        n = 0;
        while (!reg_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rstwait.reached_wait", reg_we, 1'b1);
        rst = 1'b1;
        #2;
        chk("rstwait.reg_we",    reg_we,    1'b0);
        chk("rstwait.sig_e",     sig_e,     1'b1);
        chk("rstwait.wb_count",  wb_count,  4'd0);
        chk("rstwait.busy",      busy,      1'b0);
        chk("rstwait.fwd_valid", fwd_valid, 1'b0);
        exp_q.delete();
        exp_count = '0;
        exp_sig   = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Normal operation after reset.
        push_wr(5'd5, 64'h77);
        run_entry(2'b01, 5'd5, 5'd0, 64'h77, 64'h0, 0, 1'b0, 1, "post_rst");
        // Drive the counter up to 15, then one more write wraps to 0.
        for (int k = 0; k < 7; k++) begin
            push_wr(5'(k + 1), 64'(100 + k));
            push_wr(5'(k + 16), 64'(200 + k));
            run_entry(2'b11, 5'(k + 1), 5'(k + 16), 64'(100 + k), 64'(200 + k), 0, 1'b0, 2, "fill");
        end
        chk("wrap.at_max", wb_count, 4'hF);
        push_wr(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        run_entry(2'b10, 5'd0, 5'd31, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, 1, "wrap");
        chk("wrap.zero", wb_count, 4'h0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
